stream_demux_n: RTL and testbench
=================================

Name: stream_demux_n

Overview:
- Registered, parametrised 1-to-N stream demultiplexer; the next generation of the team's 1-to-4 combinational demux.
- Routes whole packets, using valid/ready/last, from one input stream to one of N_OUT output streams.
- Channel is chosen per packet, either from a select input or by round-robin rotation.
- Sits between a single producer and N independent consumers. One-register output stage per channel.

Parameters:
- DATA_W, 8, data width in bits.
- N_OUT, 4, number of output channels, 2..16; need not be a power of 2.
- SEL_W, $clog2(N_OUT), select and channel-index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- mode  in  1  0 = select-directed, 1 = round-robin. Sampled only at packet start.
- s_data  in  DATA_W  input beat data.
- s_sel  in  SEL_W  destination channel. Sampled on the first beat only, mode 0 only.
- s_valid  in  1  input beat valid.
- s_last  in  1  final beat of the packet.
- s_ready  out  1  input may be accepted.
- m_data  out  N_OUT*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- m_valid  out  N_OUT  per-channel valid.
- m_last  out  N_OUT  per-channel last.
- m_ready  in  N_OUT  per-channel ready.
- cur_ch  out  SEL_W  channel of the packet in flight, or next round-robin target when idle.
- busy  out  1  packet in progress (FWD or DROP).
- err_sel  out  1  one-cycle pulse on the first beat of a dropped packet.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - All m_valid=0, m_last=0, m_data=0.
  - rr_ptr=0, cur_ch=0, busy=0, err_sel=0.
  - Reset mid-packet discards any buffered beats with no flush.
- Accept: a beat transfers when s_valid && s_ready at the clk edge.
- Output register: channel k is "free" when !m_valid[k] || m_ready[k].
- Latency: an accepted beat appears on m_* exactly 1 cycle later. No combinational path from s_data to m_data.
- s_ready by state:
  - IDLE: free[target].
  - FWD: free[cur_ch].
  - DROP: 1.
  - s_ready depends on m_ready combinationally; this is allowed.
- Target when idle:
  - mode=0: s_sel.
  - mode=1: rr_ptr.
- State IDLE, on an accepted beat:
  - Target valid (mode=1, or s_sel < N_OUT): load channel target, latch cur_ch=target, latched_mode=mode. If !s_last, go to FWD.
  - mode=0 and s_sel >= N_OUT: discard the beat, err_sel=1 for one cycle. If !s_last, go to DROP.
- State FWD: each accepted beat loads channel cur_ch. On the s_last beat, return to IDLE.
- State DROP: beats are consumed and discarded. On the s_last beat, return to IDLE.
- Round-robin pointer:
  - Advances only on an accepted s_last beat of a forwarded packet with latched_mode=1 (single-beat packets included).
  - rr_ptr = (rr_ptr == N_OUT-1) ? 0 : rr_ptr+1.
  - Dropped packets and mode-0 packets do not advance it.
- Mid-packet changes: changes to mode or s_sel have no effect until the next packet start.
- Simultaneous load and drain on a channel (full, m_ready=1, new beat accepted): the register takes the new beat and m_valid stays 1 without a bubble.
- Other channels: keep their buffered beats and drain independently while another packet is in flight.
- Back-pressure: s_valid=1 with the target not free means no transfer, and all state holds.
- Unused outputs: m_data for channels with m_valid=0 holds its last value. Consumers must not rely on it.

Decomposition:
- Package stream_demux_pkg:
  - State enum {IDLE, FWD, DROP}.
  - Constants MODE_SEL=1'b0, MODE_RR=1'b1.
  - Function for round-robin increment with wrap at N_OUT.
- Sub-module demux_out_reg (parameter DATA_W):
  - One-entry register slice with load, data, last, m_ready in; m_valid, m_data, m_last, free out.
  - Synchronous active-low reset.
  - Instantiated N_OUT times with a generate loop.

Test Plan:
- Reset hold: assert rst_n=0 for 2 cycles mid-packet, with m_valid=4'b0100 before reset -> m_valid=0, busy=0, cur_ch=0, s_ready=1 once rst_n=1.
- Select mode, 3-beat packet: s_sel=2, data 0xA1/0xA2/0xA3, last on the third beat -> beats appear on channel 2 one cycle after each accept, m_last[2] on 0xA3, other channels never valid.
- Back-pressure: m_ready[1]=0 after the first beat to channel 1 -> s_ready=0 and state held. Raise m_ready[1] -> second beat appears next cycle with no loss or duplication.
- Round-robin wrap, N_OUT=3, mode=1: five single-beat packets 0x10..0x14 -> routed to channels 0,1,2,0,1; rr_ptr=2 at the end.
- Invalid select, N_OUT=3, mode=0: s_sel=3, 2-beat packet -> err_sel pulses 1 cycle on the first beat, both beats consumed, no m_valid. Next packet with s_sel=0 goes to channel 0.
- Mid-packet change: flip mode and s_sel during a 4-beat packet to channel 1 -> all 4 beats go to channel 1. The new setting applies from the next packet.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg
//   Shared types and helpers for the stream_demux_n block: the packet-level
//   FSM state encoding, the routing-mode constants and the round-robin
//   pointer increment with wrap at the channel count.
package stream_demux_pkg;

  // Packet-level state of the demux front end.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // Routing modes, sampled on the first beat of each packet.
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Widest channel index needed (N_OUT up to 16 plus headroom for the count).
  localparam int SEL_MAX_W = 5;

  // Next round-robin pointer: wraps to 0 after channel n_out-1, so channel
  // counts that are not a power of two rotate correctly.
  function automatic logic [SEL_MAX_W-1:0] rr_inc(
    input logic [SEL_MAX_W-1:0] ptr,
    input logic [SEL_MAX_W-1:0] n_out
  );
    logic [SEL_MAX_W-1:0] nxt;
    if (ptr == (n_out - 5'd1)) begin
      nxt = 5'd0;
    end else begin
      nxt = ptr + 5'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/stream_demux_n_out_reg.sv
// demux_out_reg
//   One-entry output register slice for a single demux channel.
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     load_i       capture data_i/last_i this cycle (only when free_o)
//     data_i       beat data to capture
//     last_i       beat is the last of its packet
//     m_ready_i    downstream consumer ready
//     m_valid_o    register holds a beat
//     m_data_o     held beat data (holds last value when empty)
//     m_last_o     held beat last flag
//     free_o       slot can accept a beat this cycle (empty or draining)
module demux_out_reg
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              m_ready_i,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic              free_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;

  // Slot register: a load while draining replaces the beat with no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (m_ready_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign free_o    = !valid_q || m_ready_i;
  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign m_last_o  = last_q;

endmodule

// File: rtl/stream_demux_n.sv
// stream_demux_n
//   Registered 1-to-N_OUT packet demultiplexer. Whole packets are routed to
//   one channel chosen at packet start, either from s_sel (mode=0) or by a
//   round-robin pointer (mode=1). Packets with an out-of-range select are
//   consumed and dropped, flagged by a one-cycle err_sel pulse.
//   Ports:
//     clk, rst_n             clock, synchronous active-low reset
//     mode                   0 = select-directed, 1 = round-robin
//     s_data/s_sel/s_valid/s_last/s_ready   input stream
//     m_data/m_valid/m_last/m_ready         N_OUT output streams, channel k
//                                           data at [k*DATA_W +: DATA_W]
//     cur_ch                 packet channel, or next round-robin target idle
//     busy                   packet in progress (forwarding or dropping)
//     err_sel                pulse on the first beat of a dropped packet
module stream_demux_n
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = $clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [DATA_W-1:0]       s_data,
  input  logic [SEL_W-1:0]        s_sel,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic [N_OUT*DATA_W-1:0] m_data,
  output logic [N_OUT-1:0]        m_valid,
  output logic [N_OUT-1:0]        m_last,
  input  logic [N_OUT-1:0]        m_ready,
  output logic [SEL_W-1:0]        cur_ch,
  output logic                    busy,
  output logic                    err_sel
);

  // Channel count in a width that can hold N_OUT itself for range checks.
  localparam logic [SEL_W:0] N_OUT_L = (SEL_W + 1)'(N_OUT);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0] cur_ch_q, cur_ch_d;
  logic             mode_q, mode_d;
  logic             err_sel_q, err_sel_d;

  logic [SEL_W-1:0] target_s;
  logic             tgt_ok_s;
  logic             tgt_free_s;
  logic             cur_free_s;
  logic             s_ready_s;
  logic             accept_s;
  logic             load_en_s;
  logic [SEL_W-1:0] load_ch_s;
  logic [N_OUT-1:0] load_s;
  logic [N_OUT-1:0] free_s;

  // Packet-start target and whether it names a real channel.
  always_comb begin
    target_s = s_sel;
    tgt_ok_s = 1'b0;
    if (mode == MODE_RR) begin
      target_s = rr_ptr_q;
      tgt_ok_s = 1'b1;
    end else begin
      target_s = s_sel;
      tgt_ok_s = ({1'b0, s_sel} < N_OUT_L);
    end
  end

  // Free status of the start target and of the in-flight channel; an
  // out-of-range index simply matches no channel.
  always_comb begin
    tgt_free_s = 1'b0;
    cur_free_s = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      tgt_free_s = tgt_free_s | (free_s[k] & (SEL_W'(k) == target_s));
      cur_free_s = cur_free_s | (free_s[k] & (SEL_W'(k) == cur_ch_q));
    end
  end

  // Input ready: a packet being dropped, or one starting with a bad select,
  // is always consumed.
  always_comb begin
    s_ready_s = 1'b0;
    case (state_q)
      ST_IDLE: s_ready_s = tgt_ok_s ? tgt_free_s : 1'b1;
      ST_FWD:  s_ready_s = cur_free_s;
      ST_DROP: s_ready_s = 1'b1;
      default: s_ready_s = 1'b0;
    endcase
  end

  assign accept_s = s_valid && s_ready_s;

  // Next-state, channel latch, round-robin advance and slot load selection.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cur_ch_d  = cur_ch_q;
    mode_d    = mode_q;
    err_sel_d = 1'b0;
    load_en_s = 1'b0;
    load_ch_s = cur_ch_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (tgt_ok_s) begin
            load_en_s = 1'b1;
            load_ch_s = target_s;
            cur_ch_d  = target_s;
            mode_d    = mode;
            if (s_last) begin
              // Single-beat packet completes here.
              if (mode == MODE_RR) begin
                rr_ptr_d = SEL_W'(rr_inc(5'(rr_ptr_q), 5'(N_OUT)));
              end else begin
                rr_ptr_d = rr_ptr_q;
              end
            end else begin
              state_d = ST_FWD;
            end
          end else begin
            err_sel_d = 1'b1;
            if (s_last) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DROP;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FWD: begin
        if (accept_s) begin
          load_en_s = 1'b1;
          load_ch_s = cur_ch_q;
          if (s_last) begin
            state_d = ST_IDLE;
            if (mode_q == MODE_RR) begin
              rr_ptr_d = SEL_W'(rr_inc(5'(rr_ptr_q), 5'(N_OUT)));
            end else begin
              rr_ptr_d = rr_ptr_q;
            end
          end else begin
            state_d = ST_FWD;
          end
        end else begin
          state_d = ST_FWD;
        end
      end
      ST_DROP: begin
        if (accept_s && s_last) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      cur_ch_q  <= '0;
      mode_q    <= MODE_SEL;
      err_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      cur_ch_q  <= cur_ch_d;
      mode_q    <= mode_d;
      err_sel_q <= err_sel_d;
    end
  end

  // One output slot per channel.
  for (genvar k = 0; k < N_OUT; k++) begin : g_ch
    assign load_s[k] = load_en_s && (load_ch_s == SEL_W'(k));

    demux_out_reg #(
      .DATA_W (DATA_W)
    ) u_out_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (load_s[k]),
      .data_i    (s_data),
      .last_i    (s_last),
      .m_ready_i (m_ready[k]),
      .m_valid_o (m_valid[k]),
      .m_data_o  (m_data[k*DATA_W +: DATA_W]),
      .m_last_o  (m_last[k]),
      .free_o    (free_s[k])
    );
  end

  assign s_ready = s_ready_s;
  assign busy    = (state_q != ST_IDLE);
  // While idle, report where the next round-robin packet would go.
  assign cur_ch  = (state_q == ST_IDLE) ? rr_ptr_q : cur_ch_q;
  assign err_sel = err_sel_q;

endmodule

// File: tb/tb_stream_demux_n.sv
module tb_stream_demux_n;

  localparam int DW = 8;
  localparam int NO = 3;
  localparam int SW = 2;

  logic            clk;
  logic            rst_n;
  logic            mode;
  logic [DW-1:0]   s_data;
  logic [SW-1:0]   s_sel;
  logic            s_valid;
  logic            s_last;
  logic            s_ready;
  logic [NO*DW-1:0] m_data;
  logic [NO-1:0]   m_valid;
  logic [NO-1:0]   m_last;
  logic [NO-1:0]   m_ready;
  logic [SW-1:0]   cur_ch;
  logic            busy;
  logic            err_sel;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state for the randomized run.
  logic [DW:0] q [NO][$];
  int          m_rr;
  bit          m_in_pkt;
  int          m_dest;
  bit          m_pkt_rr;

  stream_demux_n #(.DATA_W(DW), .N_OUT(NO), .SEL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .s_data(s_data), .s_sel(s_sel),
    .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready), .m_data(m_data),
    .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .cur_ch(cur_ch),
    .busy(busy), .err_sel(err_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    mode = 1'b0; s_sel = 2'd0; m_ready = 3'b000;
    tick(); tick();
    n_checks++; if (m_valid !== 3'b000) begin n_fail++; $display("FAIL reset_mvalid: got %b expected 000", m_valid); end
    n_checks++; if (m_data !== 24'h0) begin n_fail++; $display("FAIL reset_mdata: got %h expected 0", m_data); end
    n_checks++; if ({busy, err_sel, cur_ch} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, err_sel, cur_ch}); end
    rst_n = 1'b1;
    // Start a packet to channel 2 with the consumer stalled, then reset mid-packet.
    s_sel = 2'd2; beat(8'h55, 1'b0);
    #1;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", s_ready); end
    tick();
    s_valid = 1'b0;
    n_checks++; if (m_valid !== 3'b100 || busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got %b/%b expected 100/1", m_valid, busy); end
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    n_checks++; if (m_valid !== 3'b000 || busy !== 1'b0 || cur_ch !== 2'd0) begin n_fail++; $display("FAIL midrst_post: got %b/%b/%0d expected 000/0/0", m_valid, busy, cur_ch); end
    s_sel = 2'd0; beat(8'h00, 1'b1);
    #1;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready_after: got %b expected 1", s_ready); end
    s_valid = 1'b0;
  endtask

  task automatic test_select_pkt();
    logic [DW-1:0] d;
    mode = 1'b0; s_sel = 2'd2; m_ready = 3'b111;
    for (int i = 0; i < 3; i++) begin
      d = 8'hA1 + 8'(i);
      beat(d, (i == 2));
      #1;
      n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL sel_ready%0d: got %b expected 1", i, s_ready); end
      tick();
      n_checks++; if (m_valid !== 3'b100 || m_data[2*DW +: DW] !== d || m_last[2] !== (i == 2)) begin
        n_fail++; $display("FAIL sel_beat%0d: got v=%b d=%h l=%b expected v=100 d=%h l=%0d", i, m_valid, m_data[2*DW +: DW], m_last[2], d, (i == 2));
      end
    end
    s_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sel_busy: got %b expected 0", busy); end
    tick();
    n_checks++; if (m_valid !== 3'b000) begin n_fail++; $display("FAIL sel_drain: got %b expected 000", m_valid); end
  endtask

  task automatic test_backpressure();
    mode = 1'b0; s_sel = 2'd1; m_ready = 3'b101;
    beat(8'hB1, 1'b0);
    tick();
    n_checks++; if (m_valid !== 3'b010 || m_data[DW +: DW] !== 8'hB1) begin n_fail++; $display("FAIL bp_first: got %b/%h expected 010/b1", m_valid, m_data[DW +: DW]); end
    beat(8'hB2, 1'b1);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready%0d: got %b expected 0", i, s_ready); end
      tick();
      n_checks++; if (m_valid !== 3'b010 || m_data[DW +: DW] !== 8'hB1 || busy !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold%0d: got %b/%h/%b expected 010/b1/1", i, m_valid, m_data[DW +: DW], busy);
      end
    end
    m_ready = 3'b111;
    #1;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", s_ready); end
    tick();
    s_valid = 1'b0;
    n_checks++; if (m_valid !== 3'b010 || m_data[DW +: DW] !== 8'hB2 || m_last[1] !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_second: got %b/%h/%b/%b expected 010/b2/1/0", m_valid, m_data[DW +: DW], m_last[1], busy);
    end
    tick();
    n_checks++; if (m_valid !== 3'b000) begin n_fail++; $display("FAIL bp_nodup: got %b expected 000", m_valid); end
  endtask

  task automatic test_rr_wrap();
    int ch;
    mode = 1'b1; s_sel = 2'd0; m_ready = 3'b111;
    for (int i = 0; i < 5; i++) begin
      ch = i % 3;
      beat(8'h10 + 8'(i), 1'b1);
      #1;
      n_checks++; if (cur_ch !== 2'(ch)) begin n_fail++; $display("FAIL rr_ptr%0d: got %0d expected %0d", i, cur_ch, ch); end
      tick();
      n_checks++; if (m_valid !== 3'(1 << ch) || m_data[ch*DW +: DW] !== 8'h10 + 8'(i)) begin
        n_fail++; $display("FAIL rr_route%0d: got %b/%h expected %b/%h", i, m_valid, m_data[ch*DW +: DW], 3'(1 << ch), 8'h10 + 8'(i));
      end
    end
    s_valid = 1'b0;
    tick();
    n_checks++; if (cur_ch !== 2'd2) begin n_fail++; $display("FAIL rr_end: got %0d expected 2", cur_ch); end
  endtask

  task automatic test_invalid_sel();
    mode = 1'b0; s_sel = 2'd3; m_ready = 3'b111;
    beat(8'h77, 1'b0);
    #1;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL bad_ready: got %b expected 1", s_ready); end
    tick();
    n_checks++; if (err_sel !== 1'b1 || m_valid !== 3'b000 || busy !== 1'b1) begin n_fail++; $display("FAIL bad_first: got %b/%b/%b expected 1/000/1", err_sel, m_valid, busy); end
    beat(8'h78, 1'b1);
    tick();
    n_checks++; if (err_sel !== 1'b0 || m_valid !== 3'b000 || busy !== 1'b0) begin n_fail++; $display("FAIL bad_second: got %b/%b/%b expected 0/000/0", err_sel, m_valid, busy); end
    s_sel = 2'd0; beat(8'h79, 1'b1);
    tick();
    s_valid = 1'b0;
    n_checks++; if (m_valid !== 3'b001 || m_data[DW-1:0] !== 8'h79 || cur_ch !== 2'd2) begin
      n_fail++; $display("FAIL bad_next: got %b/%h/%0d expected 001/79/2", m_valid, m_data[DW-1:0], cur_ch);
    end
    tick();
  endtask

  task automatic test_mid_change();
    mode = 1'b0; s_sel = 2'd1; m_ready = 3'b111;
    for (int i = 0; i < 4; i++) begin
      beat(8'hC0 + 8'(i), (i == 3));
      tick();
      mode = 1'b1; s_sel = 2'd2;
      n_checks++; if (m_valid !== 3'b010 || m_data[DW +: DW] !== 8'hC0 + 8'(i)) begin
        n_fail++; $display("FAIL mid_beat%0d: got %b/%h expected 010/%h", i, m_valid, m_data[DW +: DW], 8'hC0 + 8'(i));
      end
    end
    beat(8'hCF, 1'b1);
    tick();
    s_valid = 1'b0;
    n_checks++; if (m_valid !== 3'b100 || m_data[2*DW +: DW] !== 8'hCF || cur_ch !== 2'd0) begin
      n_fail++; $display("FAIL mid_next: got %b/%h/%0d expected 100/cf/0", m_valid, m_data[2*DW +: DW], cur_ch);
    end
    tick();
  endtask

  task automatic test_random();
    int  dst, fwd, pkt_len, beat_cnt;
    bit  exp_rdy, acc, drop_start;
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 3'b000;
    tick(); tick();
    rst_n = 1'b1;
    m_rr = 0; m_in_pkt = 1'b0; m_dest = 0; m_pkt_rr = 1'b0;
    for (int k = 0; k < NO; k++) q[k].delete();
    pkt_len = 2; beat_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      m_ready = 3'($urandom_range(0, 7));
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 8'($urandom);
      mode    = 1'($urandom);
      s_sel   = 2'($urandom);
      s_last  = (beat_cnt == pkt_len - 1);
      #1;
      if (m_in_pkt) dst = m_dest;
      else if (mode) dst = m_rr;
      else dst = (int'(s_sel) < NO) ? int'(s_sel) : -1;
      exp_rdy = (dst < 0) ? 1'b1 : ((q[dst].size() == 0) || m_ready[dst]);
      n_checks++; if (s_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, s_ready, exp_rdy); end
      for (int k = 0; k < NO; k++) begin
        if (q[k].size() != 0 && m_ready[k]) begin
          n_checks++; if ({m_last[k], m_data[k*DW +: DW]} !== q[k][0]) begin
            n_fail++; $display("FAIL rnd_drain ch%0d@%0d: got %h expected %h", k, cyc, {m_last[k], m_data[k*DW +: DW]}, q[k][0]);
          end
          void'(q[k].pop_front());
        end
      end
      acc = s_valid && exp_rdy;
      fwd = -1; drop_start = 1'b0;
      if (acc) begin
        if (!m_in_pkt) begin
          m_dest = dst; m_pkt_rr = mode;
          drop_start = (dst < 0);
        end
        if (m_dest >= 0) begin
          q[m_dest].push_back({s_last, s_data});
          fwd = m_dest;
        end
        if (s_last) begin
          if (m_dest >= 0 && m_pkt_rr) m_rr = (m_rr + 1) % NO;
          m_in_pkt = 1'b0; beat_cnt = 0; pkt_len = $urandom_range(1, 4);
        end else begin
          m_in_pkt = 1'b1; beat_cnt++;
        end
      end
      tick();
      for (int k = 0; k < NO; k++) begin
        n_checks++; if (m_valid[k] !== (q[k].size() != 0)) begin n_fail++; $display("FAIL rnd_valid ch%0d@%0d: got %b expected %0d", k, cyc, m_valid[k], (q[k].size() != 0)); end
      end
      if (fwd >= 0) begin
        n_checks++; if (m_data[fwd*DW +: DW] !== q[fwd][0][DW-1:0]) begin n_fail++; $display("FAIL rnd_latency ch%0d@%0d: got %h expected %h", fwd, cyc, m_data[fwd*DW +: DW], q[fwd][0][DW-1:0]); end
      end
      n_checks++; if (err_sel !== drop_start) begin n_fail++; $display("FAIL rnd_err@%0d: got %b expected %b", cyc, err_sel, drop_start); end
      n_checks++; if (busy !== m_in_pkt) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b expected %b", cyc, busy, m_in_pkt); end
      if (!m_in_pkt) begin
        n_checks++; if (cur_ch !== 2'(m_rr)) begin n_fail++; $display("FAIL rnd_rr@%0d: got %0d expected %0d", cyc, cur_ch, m_rr); end
      end
    end
    s_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_select_pkt();
    test_backpressure();
    test_rr_wrap();
    test_invalid_sel();
    test_mid_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
